// File: rtl/counter_bus_pkg.sv
// Shared types for the counter bus host: command opcodes, FSM states, default width.
package counter_bus_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_LOAD       = 2'b00,
        OP_COUNT_UP   = 2'b01,
        OP_COUNT_DOWN = 2'b10,
        OP_READ       = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_COUNT   = 3'd2,
        ST_READ_OE = 3'd3,
        ST_RSP     = 3'd4
    } state_e;

endpackage

// File: rtl/counter_bus_host.sv
// Command sequencer for the up/down counter macro and its shared bidirectional bus.
// All outputs are registered, decoded from the next state so they line up with it.
module counter_bus_host
    import counter_bus_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned SAMPLE_DLY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic             cnt_up,
    output logic             cnt_oe,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] bus_oe,
    input  logic [WIDTH-1:0] bus_in
);

    localparam int unsigned DLY_W = (SAMPLE_DLY > 1) ? $clog2(SAMPLE_DLY) : 1;

    state_e           state, state_n;
    logic [WIDTH-1:0] remain, remain_n;
    logic [DLY_W-1:0] dly, dly_n;
    logic             dir_n;
    logic [WIDTH-1:0] capture_n;
    logic [WIDTH-1:0] drive_n;

    // Next-state and datapath update
    always_comb begin
        state_n   = state;
        remain_n  = remain;
        dly_n     = dly;
        dir_n     = cnt_up;
        capture_n = rsp_data;
        drive_n   = '0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    unique case (op_e'(cmd_op))
                        OP_LOAD: begin
                            state_n = ST_DRIVE;
                            drive_n = cmd_data;
                        end
                        OP_COUNT_UP, OP_COUNT_DOWN: begin
                            if (cmd_data != '0) begin
                                state_n  = ST_COUNT;
                                remain_n = cmd_data;
                                dir_n    = (op_e'(cmd_op) == OP_COUNT_UP);
                            end
                        end
                        OP_READ: begin
                            state_n = ST_READ_OE;
                            dly_n   = DLY_W'(SAMPLE_DLY - 1);
                        end
                        default: ;
                    endcase
                end
            end
            ST_DRIVE: state_n = ST_IDLE;
            ST_COUNT: begin
                // remain includes the current enable cycle
                remain_n = remain - WIDTH'(1);
                if (remain == WIDTH'(1)) begin
                    state_n = ST_IDLE;
                end
            end
            ST_READ_OE: begin
                if (dly == '0) begin
                    state_n   = ST_RSP;
                    capture_n = bus_in;
                end else begin
                    dly_n = dly - DLY_W'(1);
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, datapath and registered output decode
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            remain    <= '0;
            dly       <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            cnt_en    <= 1'b0;
            cnt_load  <= 1'b0;
            cnt_up    <= 1'b0;
            cnt_oe    <= 1'b0;
            bus_out   <= '0;
            bus_oe    <= '0;
        end else begin
            state     <= state_n;
            remain    <= remain_n;
            dly       <= dly_n;
            cmd_ready <= (state_n == ST_IDLE);
            rsp_valid <= (state_n == ST_RSP);
            rsp_data  <= capture_n;
            cnt_en    <= (state_n == ST_COUNT);
            cnt_load  <= (state_n == ST_DRIVE);
            cnt_up    <= dir_n;
            cnt_oe    <= (state_n == ST_READ_OE);
            bus_out   <= drive_n;
            bus_oe    <= {WIDTH{state_n == ST_DRIVE}};
        end
    end

endmodule

// File: doc/counter_bus_host.md
# counter_bus_host

Bus-side host for the 8-bit up/down counter macro with shared tri-state load/readback bus. It accepts commands: parallel load, count up N, count down N, read back. It sequences the counter's `en`/`load`/`up`/`oe` controls and the bidirectional data bus, and guarantees no bus contention with a turnaround cycle between directions. It sits between on-chip control logic (or a host UI decoder) and the counter's pad-facing bidi bus.

## Interface
- `WIDTH`, 8: counter and bus data width.
- `SAMPLE_DLY`, 2: cycles `cnt_oe` is held before `bus_in` is captured (≥1).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op` in 2: 00 LOAD, 01 COUNT_UP, 10 COUNT_DOWN, 11 READ.
- `cmd_data` in WIDTH: load value (LOAD) or enable-cycle count N (COUNT_*); ignored for READ.
- `rsp_valid` out 1: read result valid; held until accepted.
- `rsp_ready` in 1: response consumer ready.
- `rsp_data` out WIDTH: captured counter value.
- `cnt_en`, `cnt_load`, `cnt_up`, `cnt_oe` out 1 each: counter controls.
- `bus_out` out WIDTH: host drive value for the bidi bus.
- `bus_oe` out WIDTH: per-bit host drive enable (all bits equal).
- `bus_in` in WIDTH: bidi bus sampled value.

## Operation
- States: IDLE, DRIVE, COUNT, READ_OE, RSP.
- IDLE: `cmd_ready`=1, all counter controls 0, `bus_oe`=0. On accept:
  - LOAD → DRIVE.
  - COUNT_* with N>0 → COUNT, latch N and direction.
  - COUNT_* with N=0 → stay IDLE.
  - READ → READ_OE.
- DRIVE (1 cycle): `bus_oe`=all 1s, `bus_out`=latched data, `cnt_load`=1 → IDLE.
- COUNT: `cnt_en`=1, `cnt_up`=latched direction. Remaining counter decrements each cycle. Exactly N cycles with `cnt_en`=1, then IDLE.
- READ_OE: `cnt_oe`=1 for SAMPLE_DLY cycles. `bus_in` is captured into `rsp_data` at the edge ending the last cycle → RSP.
- RSP: `cnt_oe`=0, `rsp_valid`=1, `rsp_data` stable. On `rsp_ready`=1 → IDLE.
- `cnt_up` holds its last latched value outside COUNT; its reset value is 0.
- `bus_out` is 0 whenever `bus_oe`=0.
- Contention rule: `bus_oe`≠0 and `cnt_oe`=1 never occur in the same cycle or in adjacent cycles. Both directions return through a cycle with both low (IDLE or RSP).
- `cmd_ready` is 0 in every state except IDLE. Commands are never queued.

## Timing
- Reset: state IDLE. `cmd_ready`=1 from the first cycle after reset. `rsp_valid`, `rsp_data`, `cnt_*`, `bus_out`, `bus_oe` are all 0.
- Reset mid-operation aborts. All outputs return to reset values on the next edge, and a pending response is discarded.
- Accept at edge 0:
  - LOAD: drives during cycle 1; `cmd_ready` again in cycle 2.
  - COUNT N: `cnt_en` in cycles 1..N; `cmd_ready` in cycle N+1.
  - READ: `cnt_oe` in cycles 1..SAMPLE_DLY; `rsp_valid` from cycle SAMPLE_DLY+1.
  - Minimum READ to next accept is SAMPLE_DLY+2 cycles.
- The counter wraps modulo 2^WIDTH. This block does no arithmetic on counter values.
- N counts cycles up to 2^WIDTH−1; the remaining counter is WIDTH bits.

## Structure
- Shared package `counter_bus_pkg` holds:
  - op encoding enum (LOAD/COUNT_UP/COUNT_DOWN/READ);
  - FSM state enum;
  - default `WIDTH`.
- Single module, no sub-module. The remaining-count register and capture register are inline.

## Test plan
- LOAD 0xA5, then READ → `cnt_load` pulses 1 cycle with `bus_out`=0xA5; `rsp_data`=0xA5.
- LOAD 0xFE, COUNT_UP 3, READ → exactly 3 `cnt_en` cycles with `cnt_up`=1; `rsp_data`=0x01 (wrap).
- LOAD 0x02, COUNT_DOWN 0, then COUNT_DOWN 4 → first command gives no `cnt_en` and `cmd_ready` the next cycle; read returns 0xFE.
- READ with `rsp_ready` held low 5 cycles → `rsp_valid` and `rsp_data` stable; `cmd_ready`=0 until handshake.
- Back-to-back READ/LOAD/READ with random `cmd_valid` gaps → assertion: no cycle or adjacent cycle pair has both `cnt_oe`=1 and `bus_oe`≠0.
- Assert `reset` during COUNT 200 at cycle 50 → next cycle all outputs 0, `cmd_ready`=1, no further `cnt_en`.
